// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared widths and record layout for the writeback trace buffer
package wb_trace_pkg;

    localparam int PC_W  = 32;
    localparam int DST_W = 5;
    localparam int DAT_W = 32;

    // Destination index that means "no register written this cycle"
    localparam logic [DST_W-1:0] ZERO_REG = '0;

    // Fixed-width part of a trace record; the stamp is prepended by the
    // top because its width is a per-instance parameter.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [DST_W-1:0] dst;
        logic [DAT_W-1:0] dat;
    } wb_body_t;

    localparam int BODY_W = $bits(wb_body_t);

endpackage

// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - record drain stream between trace buffer and consumer
interface wb_trace_buffer_if #(
    parameter int STAMP_W = 16
) ();
    import wb_trace_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [DST_W-1:0]   out_dst;
    logic [DAT_W-1:0]   out_dat;
    logic [STAMP_W-1:0] out_stamp;

    modport master (
        output out_valid, out_pc, out_dst, out_dat, out_stamp,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_dst, out_dat, out_stamp,
        output out_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic register-array FIFO with level count and flush
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter int  W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next pointers, level and storage; flush wins over push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage needs no reset; stale entries are never visible
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - time-stamped capture of core register writebacks
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    parameter int DROP_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en,
    input  logic                   flush,
    input  logic [PC_W-1:0]        wb_pc,
    input  logic [DST_W-1:0]       wb_dst,
    input  logic [DAT_W-1:0]       wb_dat,
    wb_trace_buffer_if.master      out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   overflow
);

    localparam int REC_W = STAMP_W + BODY_W;

    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               cap, pop, push, drop, full, empty;
    wb_body_t           cap_body, head_body;
    logic [STAMP_W-1:0] head_stamp;
    logic [REC_W-1:0]   cap_rec, head_rec;

    // Writes to the zero register are not real writebacks
    assign cap  = trace_en && (wb_dst != ZERO_REG);
    assign pop  = !empty && out_if.out_ready && !flush;
    assign push = cap && !flush && (!full || pop);
    assign drop = cap && !flush && !push;

    assign cap_body = '{pc: wb_pc, dst: wb_dst, dat: wb_dat};
    assign cap_rec  = {stamp_q, cap_body};
    assign {head_stamp, head_body} = head_rec;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cap_rec),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_rec),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    // Stamp free-runs through flush; drop accounting is cleared by flush
    always_comb begin
        stamp_d    = stamp_q + 1'b1;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (flush) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // Stamp and drop accounting registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            stamp_q    <= stamp_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Head fields are forced to zero whenever there is no record to show
    always_comb begin
        out_if.out_valid = !empty;
        out_if.out_pc    = '0;
        out_if.out_dst   = '0;
        out_if.out_dat   = '0;
        out_if.out_stamp = '0;
        if (!empty) begin
            out_if.out_pc    = head_body.pc;
            out_if.out_dst   = head_body.dst;
            out_if.out_dat   = head_body.dat;
            out_if.out_stamp = head_stamp;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        flush;
    logic [31:0] wb_pc;
    logic [4:0]  wb_dst;
    logic [31:0] wb_dat;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;
    logic        overflow;

    wb_trace_buffer_if #(.STAMP_W(4)) oif ();

    wb_trace_buffer #(
        .DEPTH   (16),
        .STAMP_W (4),
        .DROP_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trace_en (trace_en),
        .flush    (flush),
        .wb_pc    (wb_pc),
        .wb_dst   (wb_dst),
        .wb_dat   (wb_dat),
        .out_if   (oif),
        .level    (level),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] dat;
        logic [3:0]  st;
    } rec_t;

    rec_t        q[$];
    int unsigned stamp_m;
    int unsigned m_drop;
    bit          m_ovf;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  s0;
    logic [3:0]  sbase;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge with the scoreboard stepped on the same inputs
    task automatic cyc();
        rec_t r;
        bit   cap, pop, acc;
        cap = trace_en && (wb_dst != 5'd0);
        pop = (q.size() > 0) && oif.out_ready;
        if (rst) begin
            q.delete();
            stamp_m = 0;
            m_drop  = 0;
            m_ovf   = 0;
        end else begin
            if (flush) begin
                q.delete();
                m_drop = 0;
                m_ovf  = 0;
            end else begin
                acc = cap && ((q.size() < 16) || pop);
                if (pop) void'(q.pop_front());
                if (acc) begin
                    r.pc  = wb_pc;
                    r.dst = wb_dst;
                    r.dat = wb_dat;
                    r.st  = 4'(stamp_m);
                    q.push_back(r);
                end else if (cap) begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            stamp_m = (stamp_m + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        bit v;
        v = (q.size() > 0);
        chk({tag, "_valid"}, 64'(oif.out_valid), 64'(v));
        chk({tag, "_level"}, 64'(level), 64'(q.size()));
        chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
        chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        if (v) begin
            chk({tag, "_pc"}, 64'(oif.out_pc), 64'(q[0].pc));
            chk({tag, "_dst"}, 64'(oif.out_dst), 64'(q[0].dst));
            chk({tag, "_dat"}, 64'(oif.out_dat), 64'(q[0].dat));
            chk({tag, "_stamp"}, 64'(oif.out_stamp), 64'(q[0].st));
        end else begin
            chk({tag, "_pc0"}, 64'(oif.out_pc), 64'd0);
            chk({tag, "_stamp0"}, 64'(oif.out_stamp), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; trace_en = 1'b0; flush = 1'b0;
        wb_pc = '0; wb_dst = '0; wb_dat = '0;
        oif.out_ready = 1'b0;
        stamp_m = 0; m_drop = 0; m_ovf = 0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", 64'(oif.out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_pc", 64'(oif.out_pc), 64'd0);

        // 1: single capture, held while out_ready is low
        cyc();
        trace_en = 1'b1; wb_dst = 5'd3; wb_dat = 32'hDEADBEEF; wb_pc = 32'h10;
        cyc();
        trace_en = 1'b0; wb_dst = 5'd0;
        chk("t1_valid", 64'(oif.out_valid), 64'd1);
        chk("t1_dat", 64'(oif.out_dat), 64'hDEADBEEF);
        chk("t1_dst", 64'(oif.out_dst), 64'd3);
        chk("t1_pc", 64'(oif.out_pc), 64'h10);
        chk("t1_stamp", 64'(oif.out_stamp), 64'd1);
        chk("t1_level", 64'(level), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_hold_dat", 64'(oif.out_dat), 64'hDEADBEEF);
            chk("t1_hold_stamp", 64'(oif.out_stamp), 64'd1);
            chk("t1_hold_valid", 64'(oif.out_valid), 64'd1);
        end
        oif.out_ready = 1'b1;
        cyc();
        oif.out_ready = 1'b0;
        chk("t1_drained", 64'(oif.out_valid), 64'd0);
        check_all("t1_end");

        // 2: zero destination and disabled capture both ignored
        trace_en = 1'b1; wb_dst = 5'd0; wb_pc = 32'h20; wb_dat = 32'h1;
        cyc();
        chk("t2_zero_level", 64'(level), 64'd0);
        chk("t2_zero_valid", 64'(oif.out_valid), 64'd0);
        trace_en = 1'b0; wb_dst = 5'd5;
        cyc();
        chk("t2_dis_level", 64'(level), 64'd0);
        chk("t2_dis_valid", 64'(oif.out_valid), 64'd0);

        // 3: 20 captures into 16 entries
        trace_en = 1'b1;
        s0 = 4'(stamp_m);
        for (int i = 0; i < 20; i++) begin
            wb_dst = 5'(i % 31 + 1);
            wb_dat = 32'h1000 + 32'(i);
            wb_pc  = 32'(4 * i);
            cyc();
        end
        trace_en = 1'b0; wb_dst = 5'd0;
        chk("t3_level", 64'(level), 64'd16);
        chk("t3_drop", 64'(drop_cnt), 64'd4);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_head", 64'(oif.out_dat), 64'h1000);
        chk("t3_head_stamp", 64'(oif.out_stamp), 64'(s0));

        // 4: full with simultaneous pop and capture
        oif.out_ready = 1'b1; trace_en = 1'b1; wb_dst = 5'd7;
        wb_dat = 32'hCAFE0000; wb_pc = 32'h400;
        cyc();
        trace_en = 1'b0; wb_dst = 5'd0;
        chk("t4_level", 64'(level), 64'd16);
        chk("t4_drop", 64'(drop_cnt), 64'd4);
        for (int i = 1; i < 16; i++) begin
            chk("t3_order_dat", 64'(oif.out_dat), 64'h1000 + 64'(i));
            chk("t3_order_stamp", 64'(oif.out_stamp), 64'(4'(s0 + 4'(i))));
            check_all("t3_drain");
            cyc();
        end
        chk("t4_last_dat", 64'(oif.out_dat), 64'hCAFE0000);
        chk("t4_last_stamp", 64'(oif.out_stamp), 64'(4'(s0 + 4'd4)));
        cyc();
        chk("t4_empty", 64'(oif.out_valid), 64'd0);

        // 5: streaming capture and drain, stamp wraps several times
        trace_en = 1'b1;
        sbase = 4'(stamp_m);
        for (int i = 0; i < 100; i++) begin
            wb_dst = 5'(i % 31 + 1);
            wb_dat = 32'h2000 + 32'(i);
            wb_pc  = 32'h8000 + 32'(4 * i);
            cyc();
            chk("t5_lvl_le1", 64'(level <= 5'd1), 64'd1);
            chk("t5_dat", 64'(oif.out_dat), 64'h2000 + 64'(i));
            chk("t5_stamp", 64'(oif.out_stamp), 64'(4'(sbase + 4'(i))));
        end
        trace_en = 1'b0; wb_dst = 5'd0;
        cyc();
        chk("t5_empty", 64'(oif.out_valid), 64'd0);
        chk("t5_drop", 64'(drop_cnt), 64'd4);
        oif.out_ready = 1'b0;

        // 6a: flush with a simultaneous capture
        trace_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wb_dst = 5'd4; wb_dat = 32'h3000 + 32'(i); wb_pc = 32'h600;
            cyc();
        end
        chk("t6_level7", 64'(level), 64'd7);
        flush = 1'b1; wb_dst = 5'd9; wb_dat = 32'h9999;
        cyc();
        flush = 1'b0; trace_en = 1'b0; wb_dst = 5'd0;
        chk("t6_fl_level", 64'(level), 64'd0);
        chk("t6_fl_valid", 64'(oif.out_valid), 64'd0);
        chk("t6_fl_drop", 64'(drop_cnt), 64'd0);
        chk("t6_fl_ovf", 64'(overflow), 64'd0);
        cyc();
        check_all("t6_after_flush");

        // 6b: reset in the middle of a drain
        trace_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wb_dst = 5'd6; wb_dat = 32'h4000 + 32'(i); wb_pc = 32'h700;
            cyc();
        end
        trace_en = 1'b0; wb_dst = 5'd0; oif.out_ready = 1'b1;
        cyc();
        cyc();
        chk("t6_mid_level", 64'(level), 64'd3);
        rst = 1'b1;
        cyc();
        rst = 1'b0; oif.out_ready = 1'b0;
        chk("t6_rst_valid", 64'(oif.out_valid), 64'd0);
        chk("t6_rst_level", 64'(level), 64'd0);
        chk("t6_rst_dat", 64'(oif.out_dat), 64'd0);
        chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
        trace_en = 1'b1; wb_dst = 5'd2; wb_dat = 32'h55; wb_pc = 32'h44;
        cyc();
        trace_en = 1'b0; wb_dst = 5'd0;
        chk("t6_rst_stamp", 64'(oif.out_stamp), 64'd0);
        chk("t6_rst_cap", 64'(oif.out_dat), 64'h55);
        check_all("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
